// File: rtl/move_pkg.sv
// move_pkg: shared encodings and helpers for the move key scheduler.
//   DIR_*     : command direction codes driven on cmd_dir
//   state_t   : scheduler FSM states
//   KEY_DIR   : key bit -> direction code map (bit0 up .. bit3 right)
//   rr_pick   : round-robin search over pending requests
//   key_dir   : direction code for a key bit index
package move_pkg;
  localparam int NKEYS = 4;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam logic [7:0] KEY_DIR = {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  // Returns {found, index}; searches last+1 .. last+4 (mod 4), nearest wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = {1'b0, last};
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction
  function automatic logic [1:0] key_dir(input logic [1:0] k);
    return KEY_DIR[{k, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/key_filter.sv
// key_filter: debounces one raw key and emits a one-cycle press pulse.
//   clk, rst_n : clock, async active-low reset
//   raw        : raw key level
//   filtered   : debounced level, follows raw after DEBOUNCE_CYCLES stable cycles
//   press      : one-cycle pulse the cycle after filtered rises
module key_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic filt_d;
  logic diff;
  assign diff = raw ^ filtered;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
      filt_d   <= 1'b0;
      press    <= 1'b0;
    end else begin
      cnt      <= (diff && cnt != LAST) ? cnt + 1'b1 : '0;
      filtered <= (diff && cnt == LAST) ? ~filtered : filtered;
      filt_d   <= filtered;
      press    <= filtered & ~filt_d;
    end
  end
endmodule

// File: rtl/move_key_scheduler.sv
// move_key_scheduler: debounces four direction keys, buffers presses and
// issues them one at a time, round-robin, to the move engine.
//   clk, rst_n : clock, async active-low reset
//   key_raw    : raw keys, bit0 up, bit1 down, bit2 left, bit3 right
//   enable     : game active; low clears and blocks pending requests
//   cmd_ready  : engine accepts the offered command
//   move_done  : engine finished the accepted move (one-cycle pulse)
//   cmd_valid  : command offered
//   cmd_dir    : offered direction (meaningful while cmd_valid)
//   busy       : scheduler not idle
//   pending    : buffered request bits
module move_key_scheduler
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_raw,
  input  logic       enable,
  input  logic       cmd_ready,
  input  logic       move_done,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic       busy,
  output logic [3:0] pending
);
  state_t state, state_n;
  logic [1:0] last_grant, last_n, dir_n, g;
  logic [3:0] press, level_unused, clr, pending_n;
  logic valid_n, hit;
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (key_raw[i]),
      .filtered (level_unused[i]),
      .press    (press[i])
    );
  end
  always_comb begin
    {hit, g} = rr_pick(pending, last_grant);
    state_n  = state;
    valid_n  = cmd_valid;
    dir_n    = cmd_dir;
    last_n   = last_grant;
    clr      = '0;
    case (state)
      IDLE: if (enable && hit) begin
        state_n = ISSUE;
        valid_n = 1'b1;
        dir_n   = key_dir(g);
        last_n  = g;
        clr     = 4'b0001 << g;
      end
      ISSUE: if (cmd_ready) begin
        state_n = WAIT_DONE;
        valid_n = 1'b0;
      end
      WAIT_DONE: if (move_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A press arriving on the bit being granted re-arms it (set beats clear).
    pending_n = enable ? (pending & ~clr) | press : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= DIR_RIGHT;
      cmd_valid  <= 1'b0;
      cmd_dir    <= DIR_UP;
      busy       <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      cmd_valid  <= valid_n;
      cmd_dir    <= dir_n;
      busy       <= state_n != IDLE;
      pending    <= pending_n;
    end
  end
endmodule

// File: tb/tb_move_key_scheduler.sv
// tb_move_key_scheduler: directed and random stimulus against a behavioural model.
module tb_move_key_scheduler;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] key_raw = '0;
  logic enable = 1'b0, cmd_ready = 1'b0, move_done = 1'b0;
  logic cmd_valid, busy;
  logic [1:0] cmd_dir;
  logic [3:0] pending;

  move_key_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .enable(enable),
    .cmd_ready(cmd_ready), .move_done(move_done), .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  logic [3:0] hist[$];
  logic [3:0] m_filt, m_prev, m_press, m_pend;
  logic m_valid;
  logic [1:0] m_dir;
  int m_phase, m_last, done_cnt, done_delay, n_cmp, n_err, n_cmds;
  bit rand_done;
  logic [1:0] dirs[$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_filt = '0; m_prev = '0; m_press = '0; m_pend = '0;
    m_phase = 0; m_valid = 1'b0; m_dir = 2'd0; m_last = 3; done_cnt = -1;
  endtask

  task automatic model_edge();
    logic [3:0] nf, pend_n;
    int g;
    bit all;
    hist.push_back(key_raw);
    if (hist.size() > D) void'(hist.pop_front());
    nf = m_filt;
    for (int i = 0; i < 4; i++) begin
      all = (hist.size() == D);
      foreach (hist[j]) if (hist[j][i] == m_filt[i]) all = 0;
      if (all) nf[i] = ~m_filt[i];
    end
    g = -1;
    if (m_phase == 0 && enable)
      for (int k = 1; k <= 4; k++) if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
    pend_n = enable ? m_pend : 4'd0;
    if (g >= 0) pend_n[g] = 1'b0;
    if (enable) pend_n = pend_n | m_press;
    case (m_phase)
      0: if (g >= 0) begin m_phase = 1; m_valid = 1'b1; m_dir = g[1:0]; m_last = g; end
      1: if (cmd_ready) begin m_phase = 2; m_valid = 1'b0; done_cnt = done_delay; end
      default: if (move_done) m_phase = 0;
    endcase
    m_press = m_filt & ~m_prev;
    m_prev = m_filt;
    m_filt = nf;
    m_pend = pend_n;
  endtask

  task automatic check_all();
    chk("cmd_valid", 4'(cmd_valid), 4'(m_valid));
    chk("cmd_dir", 4'(cmd_dir), 4'(m_dir));
    chk("busy", 4'(busy), 4'(m_phase != 0));
    chk("pending", pending, m_pend);
  endtask

  task automatic step();
    if (cmd_valid && cmd_ready) begin dirs.push_back(cmd_dir); n_cmds++; end
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    move_done = (done_cnt == 0) || (rand_done && $urandom_range(0, 7) == 0);
    if (done_cnt >= 0) done_cnt--;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    move_done = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmds = 0;
    dirs.delete();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_delay = 5; rand_done = 0;
    enable = 1'b1; cmd_ready = 1'b1;
    do_reset();
    // clean press held 10 cycles: one up command only
    key_raw = 4'b0001; steps(10);
    key_raw = 4'b0000; steps(14);
    chk("clean_cmds", 4'(n_cmds), 4'd1);
    chk("clean_dir", dirs.size() > 0 ? 4'(dirs[0]) : 4'hF, 4'd0);
    chk("clean_idle", 4'(busy), 4'd0);
    // bounce on right key
    n_cmds = 0;
    key_raw = 4'b1000; step(); key_raw = 4'b0000; step();
    key_raw = 4'b1000; step(); key_raw = 4'b0000; step();
    key_raw = 4'b1000; step(); key_raw = 4'b0000; steps(10);
    chk("bounce_cmds", 4'(n_cmds), 4'd0);
    chk("bounce_pend", pending, 4'd0);
    // round robin from reset
    do_reset();
    key_raw = 4'hF; steps(50);
    key_raw = 4'h0; steps(8);
    chk("rr_cmds", 4'(n_cmds), 4'd4);
    for (int i = 0; i < 4; i++) chk("rr_dir", dirs.size() > i ? 4'(dirs[i]) : 4'hF, 4'(i));
    // busy buffering: left held off by cmd_ready=0 while up pressed twice
    do_reset();
    cmd_ready = 1'b0;
    key_raw = 4'b0100; steps(8);
    for (int r = 0; r < 24; r++) begin
      key_raw = (r % 12 < 6) ? 4'b0001 : 4'b0000;
      step();
      chk("hold_valid", 4'(cmd_valid), 4'd1);
      chk("hold_dir", 4'(cmd_dir), 4'd2);
    end
    chk("hold_pend", pending, 4'b0001);
    cmd_ready = 1'b1; steps(30);
    chk("buf_cmds", 4'(n_cmds), 4'd2);
    chk("buf_up", dirs.size() > 1 ? 4'(dirs[1]) : 4'hF, 4'd0);
    // enable gating with a command in flight
    do_reset();
    cmd_ready = 1'b0;
    key_raw = 4'b0010; steps(8);
    key_raw = 4'b0101; steps(8);
    chk("gate_pend_set", pending, 4'b0101);
    enable = 1'b0; step();
    chk("gate_pend_clr", pending, 4'd0);
    key_raw = 4'b0000; steps(6);
    key_raw = 4'b0101; steps(8);
    chk("gate_ignored", pending, 4'd0);
    key_raw = 4'b0000; steps(6);
    cmd_ready = 1'b1; steps(10);
    chk("gate_cmds", 4'(n_cmds), 4'd1);
    chk("gate_idle", 4'(busy), 4'd0);
    enable = 1'b1; steps(5);
    chk("gate_no_more", 4'(n_cmds), 4'd1);
    // asynchronous reset while a command is offered
    cmd_ready = 1'b0;
    key_raw = 4'b1000; steps(8);
    chk("pre_rst_valid", 4'(cmd_valid), 4'd1);
    #3;
    do_reset();
    key_raw = 4'hF; cmd_ready = 1'b1; steps(12);
    chk("post_rst_dir", dirs.size() > 0 ? 4'(dirs[0]) : 4'hF, 4'd0);
    // random traffic
    do_reset();
    rand_done = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) key_raw[i] = ~key_raw[i];
      enable = ($urandom_range(0, 19) != 0);
      cmd_ready = ($urandom_range(0, 2) != 0);
      done_delay = $urandom_range(0, 4);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
